// File: rtl/sub_sched64_pkg.sv
// Shared types and default sizing for the shared-subtractor scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state type, default WIDTH/SLICE, derived slice count and
// slice-counter width.
package sub_sched_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_SLICE = 16;
    localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;
    localparam int CNT_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_sched64_if.sv
// Bundle of the two requester channels, the result channel and busy.
// Latency: n/a (wires only).
// Backpressure: req ready driven by the scheduler, res ready by the consumer.
// master: requesters + result consumer side. slave: the scheduler.
// Optional macro SUB_OVF_EN adds res_ovf to the result channel.
interface sub_sched64_if
    import sub_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_d;
    logic             res_bout;
    logic             res_id;
    logic             busy;
`ifdef SUB_OVF_EN
    logic             res_ovf;
`endif

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        output res_ready,
        input  res_valid, res_d, res_bout, res_id,
        input  busy
`ifdef SUB_OVF_EN
        , input res_ovf
`endif
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        input  res_ready,
        output res_valid, res_d, res_bout, res_id,
        output busy
`ifdef SUB_OVF_EN
        , output res_ovf
`endif
    );

endinterface

// File: rtl/sub_sched64_fs_slice.sv
// SLICE-bit borrow-ripple subtractor: d = a - b - bin, bout = borrow out.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (minuend/subtrahend slice), bin (borrow in), d, bout.
module fs_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] d,
    output logic             bout
);

    logic br;

    always_comb begin
        br = bin;
        d  = '0;
        for (int i = 0; i < SLICE; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            // Borrow when a<b at this bit, or equal bits with incoming borrow.
            br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/sub_sched64.sv
// Round-robin scheduler sharing one SLICE-bit subtractor between two requesters.
// Latency: result valid WIDTH/SLICE edges after the accepting edge.
// Backpressure: result held in DONE until res_ready; no request accepted unless IDLE.
// Ports: clk, rst (async, active-high), bus (slave modport: req0/req1 valid-ready
// operand channels, res valid-ready result channel with id/borrow, busy).
// Optional macro SUB_OVF_EN adds the registered two's-complement overflow res_ovf.
module sub_sched64
    import sub_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic         clk,
    input  logic         rst,
    sub_sched64_if.slave bus
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NS - 1);

    state_t           state_q, state_d;
    logic             ptr_q;
    logic [WIDTH-1:0] a_q, b_q, d_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             id_q;
`ifdef SUB_OVF_EN
    logic             as_q, bs_q;
    logic             ovf_q;
`endif

    logic             grant0, grant1;
    logic             accept, step, last;
    logic [SLICE-1:0] diff;
    logic             bout;

    fs_slice #(.SLICE(SLICE)) u_fs (
        .a    (a_q[SLICE-1:0]),
        .b    (b_q[SLICE-1:0]),
        .bin  (borrow_q),
        .d    (diff),
        .bout (bout)
    );

    // Next state and arbitration. ptr_q names the requester that wins a tie.
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
                grant1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);
                accept = grant0 | grant1;
                if (accept) state_d = RUN;
            end
            RUN: begin
                step = 1'b1;
                last = (cnt_q == LAST_CNT);
                if (last) state_d = DONE;
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Readys are masked during reset so nothing looks accepted while flops are held.
    assign bus.req0_ready = grant0 & ~rst;
    assign bus.req1_ready = grant1 & ~rst;
    assign bus.res_valid  = (state_q == DONE);
    assign bus.res_d      = d_q;
    assign bus.res_bout   = borrow_q;
    assign bus.res_id     = id_q;
    assign bus.busy       = (state_q != IDLE);
`ifdef SUB_OVF_EN
    assign bus.res_ovf    = ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            id_q     <= 1'b0;
`ifdef SUB_OVF_EN
            as_q     <= 1'b0;
            bs_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= grant1 ? bus.req1_a : bus.req0_a;
                b_q      <= grant1 ? bus.req1_b : bus.req0_b;
                id_q     <= grant1;
                // Hand priority to whichever requester was not just served.
                ptr_q    <= ~grant1;
                borrow_q <= 1'b0;
                cnt_q    <= '0;
`ifdef SUB_OVF_EN
                // Sign bits are shifted out during RUN, so keep them aside.
                as_q     <= grant1 ? bus.req1_a[WIDTH-1] : bus.req0_a[WIDTH-1];
                bs_q     <= grant1 ? bus.req1_b[WIDTH-1] : bus.req0_b[WIDTH-1];
`endif
            end
            if (step) begin
                // LSB slice first: each difference enters at the top and walks down.
                d_q      <= {diff, d_q[WIDTH-1:SLICE]};
                a_q      <= a_q >> SLICE;
                b_q      <= b_q >> SLICE;
                borrow_q <= bout;
                cnt_q    <= cnt_q + CW'(1);
`ifdef SUB_OVF_EN
                // The last slice's top bit is the result MSB.
                if (last) ovf_q <= (as_q ^ bs_q) & (diff[SLICE-1] ^ as_q);
`endif
            end
        end
    end

endmodule

// File: tb/tb_sub_sched64.sv
// Directed bench for sub_sched64.
// Latency: checks result 4 edges after accept, 6-cycle issue period.
// Backpressure: exercises res_ready low in DONE and mid-RUN reset.
module tb_sub_sched64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nfail = 0;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    sub_sched64_if #(.WIDTH(64)) bus ();

    sub_sched64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0] exp_d  [2];
        logic        exp_bo [2];

        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.res_ready  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_d", bus.res_d, 64'd0);
        chk("rst_bout", 64'(bus.res_bout), 64'd0);
        chk("rst_id", 64'(bus.res_id), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;

        // req0 alone: 100 - 1
        bus.req0_valid = 1'b1;
        bus.req0_a     = 64'd100;
        bus.req0_b     = 64'd1;
        bus.res_ready  = 1'b1;
        #1;
        chk("t1_rdy0", 64'(bus.req0_ready), 64'd1);
        chk("t1_rdy1", 64'(bus.req1_ready), 64'd0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t1_busy", 64'(bus.busy), 64'd1);
        chk("t1_rdy0_run", 64'(bus.req0_ready), 64'd0);
        repeat (3) tick();
        chk("t1_early", 64'(bus.res_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(bus.res_valid), 64'd1);
        chk("t1_d", bus.res_d, 64'd99);
        chk("t1_bout", 64'(bus.res_bout), 64'd0);
        chk("t1_id", 64'(bus.res_id), 64'd0);
        tick();
        chk("t1_valid_off", 64'(bus.res_valid), 64'd0);
        chk("t1_busy_off", 64'(bus.busy), 64'd0);

        // req1 alone: 0 - 1 borrows through every slice
        bus.req1_valid = 1'b1;
        bus.req1_a     = 64'd0;
        bus.req1_b     = 64'd1;
        #1;
        chk("t2_rdy1", 64'(bus.req1_ready), 64'd1);
        tick();
        bus.req1_valid = 1'b0;
        repeat (4) tick();
        chk("t2_valid", 64'(bus.res_valid), 64'd1);
        chk("t2_d", bus.res_d, ALL1);
        chk("t2_bout", 64'(bus.res_bout), 64'd1);
        chk("t2_id", 64'(bus.res_id), 64'd1);
        tick();

        // Both valid from reset: alternate 0,1,0,1 at a 6-cycle period
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_a     = 64'd1000;
        bus.req0_b     = 64'd1;
        bus.req1_valid = 1'b1;
        bus.req1_a     = 64'h10;
        bus.req1_b     = 64'h20;
        exp_d[0]  = 64'd999;
        exp_bo[0] = 1'b0;
        exp_d[1]  = 64'hFFFF_FFFF_FFFF_FFF0;
        exp_bo[1] = 1'b1;
        #1;
        chk("t3_rdy0_in_rst", 64'(bus.req0_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t3_first_rdy0", 64'(bus.req0_ready), 64'd1);
        chk("t3_first_rdy1", 64'(bus.req1_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            repeat (3) tick();
            chk($sformatf("t3_early%0d", i), 64'(bus.res_valid), 64'd0);
            tick();
            chk($sformatf("t3_valid%0d", i), 64'(bus.res_valid), 64'd1);
            chk($sformatf("t3_id%0d", i), 64'(bus.res_id), 64'(i % 2));
            chk($sformatf("t3_d%0d", i), bus.res_d, exp_d[i % 2]);
            chk($sformatf("t3_bout%0d", i), 64'(bus.res_bout), 64'(exp_bo[i % 2]));
            tick();
            chk($sformatf("t3_off%0d", i), 64'(bus.res_valid), 64'd0);
            chk($sformatf("t3_next_rdy0_%0d", i), 64'(bus.req0_ready), 64'((i + 1) % 2 == 0));
            chk($sformatf("t3_next_rdy1_%0d", i), 64'(bus.req1_ready), 64'((i + 1) % 2 == 1));
        end

        // res_ready low in DONE for 5 cycles
        bus.res_ready  = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a     = 64'd50;
        bus.req0_b     = 64'd8;
        #1;
        tick();
        repeat (4) tick();
        chk("t4_valid", 64'(bus.res_valid), 64'd1);
        chk("t4_d", bus.res_d, 64'd42);
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t4_hold_valid%0d", i), 64'(bus.res_valid), 64'd1);
            chk($sformatf("t4_hold_d%0d", i), bus.res_d, 64'd42);
            chk($sformatf("t4_hold_id%0d", i), 64'(bus.res_id), 64'd0);
            chk($sformatf("t4_hold_rdy0_%0d", i), 64'(bus.req0_ready), 64'd0);
            chk($sformatf("t4_hold_rdy1_%0d", i), 64'(bus.req1_ready), 64'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        chk("t4_consumed", 64'(bus.res_valid), 64'd0);
        chk("t4_next_rdy1", 64'(bus.req1_ready), 64'd1);
        chk("t4_next_rdy0", 64'(bus.req0_ready), 64'd0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("t4_busy", 64'(bus.busy), 64'd1);

        // Reset two cycles after accept discards the in-flight op
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t5_valid", 64'(bus.res_valid), 64'd0);
        chk("t5_d", bus.res_d, 64'd0);
        chk("t5_bout", 64'(bus.res_bout), 64'd0);
        chk("t5_id", 64'(bus.res_id), 64'd0);
        chk("t5_busy", 64'(bus.busy), 64'd0);
`ifdef SUB_OVF_EN
        chk("t5_ovf", 64'(bus.res_ovf), 64'd0);
`endif
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t5_no_result%0d", i), 64'(bus.res_valid), 64'd0);
        end
        bus.req0_valid = 1'b1;
        bus.req0_a     = 64'h1_0000;
        bus.req0_b     = 64'h1;
        #1;
        chk("t5_rdy0", 64'(bus.req0_ready), 64'd1);
        tick();
        bus.req0_valid = 1'b0;
        repeat (4) tick();
        chk("t5_after_valid", 64'(bus.res_valid), 64'd1);
        chk("t5_after_d", bus.res_d, 64'hFFFF);
        chk("t5_after_bout", 64'(bus.res_bout), 64'd0);
        chk("t5_after_id", 64'(bus.res_id), 64'd0);
        tick();

`ifdef SUB_OVF_EN
        // Signed overflow flag
        bus.req0_valid = 1'b1;
        bus.req0_a     = 64'h7FFF_FFFF_FFFF_FFFF;
        bus.req0_b     = ALL1;
        tick();
        bus.req0_valid = 1'b0;
        repeat (4) tick();
        chk("t6_d", bus.res_d, 64'h8000_0000_0000_0000);
        chk("t6_ovf", 64'(bus.res_ovf), 64'd1);
        chk("t6_bout", 64'(bus.res_bout), 64'd1);
        tick();
        bus.req0_valid = 1'b1;
        bus.req0_a     = 64'd5;
        bus.req0_b     = 64'd3;
        tick();
        bus.req0_valid = 1'b0;
        repeat (4) tick();
        chk("t6b_d", bus.res_d, 64'd2);
        chk("t6b_ovf", 64'(bus.res_ovf), 64'd0);
        chk("t6b_bout", 64'(bus.res_bout), 64'd0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
